led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Multi-channel LED pattern/PWM sequencer with staged config.
//               Optional PWM mode is built when LED_SEQ_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int CHANNELS = 6,
  parameter int STEP_W   = 4,
  parameter int TICK_DIV = 10000000,
  parameter int PWM_W    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      led_enable,
  input  logic                     mtne_mode,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [3:0]               cfg_chan,
  input  logic [1:0]               cfg_mode,
  input  logic [(1<<STEP_W)-1:0]   cfg_pattern,
  output logic [CHANNELS-1:0]      led_output,
  output logic [STEP_W-1:0]        step_index,
  output logic                     cfg_error
);

  localparam int              STEPS      = 1 << STEP_W;
  localparam int              PRE_W      = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0]      C_NCHAN    = 5'(CHANNELS);
  localparam logic [1:0]      C_MODE_OFF = 2'b00;
  localparam logic [1:0]      C_MODE_ON  = 2'b01;
  localparam logic [1:0]      C_MODE_PAT = 2'b10;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                w_tick;

  logic                stg_valid_q, stg_valid_d;
  logic [3:0]          stg_chan_q, stg_chan_d;
  logic [1:0]          stg_mode_q, stg_mode_d;
  logic [STEPS-1:0]    stg_pat_q, stg_pat_d;
  logic                err_q, err_d;
  logic                w_accept, w_bad, w_apply;

  logic [CHANNELS-1:0] led_q, led_d;

  assign w_tick  = (presc_q == C_PRE_LAST);
  assign presc_d = w_tick ? '0 : presc_q + 1'b1;
  assign step_d  = w_tick ? step_q + 1'b1 : step_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end
`endif

  // Ready is forced high during reset because the slot is being discarded.
  assign cfg_ready = ~stg_valid_q | reset;
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_bad     = ({1'b0, cfg_chan} >= C_NCHAN);
  assign w_apply   = stg_valid_q & w_tick;

  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_chan_d  = stg_chan_q;
    stg_mode_d  = stg_mode_q;
    stg_pat_d   = stg_pat_q;
    err_d       = 1'b0;
    if (w_apply) begin
      stg_valid_d = 1'b0;
    end
    if (w_accept) begin
      if (w_bad) begin
        err_d = 1'b1;
      end else begin
        stg_valid_d = 1'b1;
        stg_chan_d  = cfg_chan;
        stg_mode_d  = cfg_mode;
        stg_pat_d   = cfg_pattern;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_chan_q  <= '0;
      stg_mode_q  <= '0;
      stg_pat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_chan_q  <= stg_chan_d;
      stg_mode_q  <= stg_mode_d;
      stg_pat_q   <= stg_pat_d;
      err_q       <= err_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [STEPS-1:0] C_RST_PAT =
      {{(STEPS-1){1'b0}}, 1'b1} << ((i + 1) % STEPS);

    logic [1:0]       mode_q;
    logic [STEPS-1:0] pat_q;
    logic             w_hit, w_pwm_on, w_drive;

    assign w_hit = w_apply && (stg_chan_q == 4'(i));

    always_ff @(posedge clock) begin
      if (reset) begin
        mode_q <= C_MODE_PAT;
        pat_q  <= C_RST_PAT;
      end else if (w_hit) begin
        mode_q <= stg_mode_q;
        pat_q  <= stg_pat_q;
      end
    end

`ifdef LED_SEQ_PWM_EN
    assign w_pwm_on = (pwm_cnt_q < pat_q[PWM_W-1:0]);
`else
    assign w_pwm_on = pat_q[step_q];
`endif

    always_comb begin
      w_drive = 1'b0;
      if (mtne_mode) begin
        w_drive = 1'b1;
      end else if (led_enable[i]) begin
        case (mode_q)
          C_MODE_OFF: w_drive = 1'b0;
          C_MODE_ON:  w_drive = 1'b1;
          C_MODE_PAT: w_drive = pat_q[step_q];
          default:    w_drive = w_pwm_on;
        endcase
      end
    end

    assign led_d[i] = w_drive;
  end

  always_ff @(posedge clock) begin
    if (reset) led_q <= '0;
    else       led_q <= led_d;
  end

  assign led_output = led_q;
  assign step_index = step_q;
  assign cfg_error  = err_q;

endmodule
`default_nettype wire
